// File: rtl/conv_result_writer.sv
// conv_result_writer
//
// Write-back end of the convolution block-memory interface. Accepts the
// saturated 16-bit convolution output stream, packs pairs of results into
// 32-bit words (first sample in the low half) and writes them into block
// memory starting at RESULT_BASE_WORD. An odd final sample is written as a
// half word on the low two byte lanes. Completion is reported through the
// sticky oDONE flag.
//
// Ports:
//   iCLK        clock
//   iRSTn       asynchronous active-low reset
//   iSTART      level from the AXI control register; a run starts on its rising edge
//   iY          signed convolution result
//   iValid      iY valid this cycle
//   oBLK_ADDR   block memory word address
//   oBLK_WDATA  block memory write data
//   oBLK_EN     block memory enable (one-cycle write strobe)
//   oBLK_WE     byte write enables
//   oBUSY       run in progress
//   oDONE       sticky: run complete
//   oDROP       sticky: a valid sample arrived while not armed

module conv_result_writer #(
    parameter int ADDR_WIDTH       = 12,
    parameter int DATA_WIDTH       = 32,
    parameter int WEA_WIDTH        = 4,
    parameter int RESULT_BASE_WORD = 'h200,
    parameter int RESULT_COUNT     = 576,
    parameter int CNT_WIDTH        = 10
) (
    input  logic                    iCLK,
    input  logic                    iRSTn,
    input  logic                    iSTART,
    input  logic [15:0]             iY,
    input  logic                    iValid,
    output logic [ADDR_WIDTH-3:0]   oBLK_ADDR,
    output logic [DATA_WIDTH-1:0]   oBLK_WDATA,
    output logic                    oBLK_EN,
    output logic [WEA_WIDTH-1:0]    oBLK_WE,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic                    oDROP
);

    localparam int WAW = ADDR_WIDTH - 2;
    localparam logic [WAW-1:0]       BASE = WAW'(RESULT_BASE_WORD);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(RESULT_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 start_d;
    logic                 start_pulse;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [WAW-1:0]       ptr;
    logic                 half;
    logic [15:0]          lo;
    logic                 accept;
    logic                 last;

    assign start_pulse = iSTART & ~start_d;
    assign accept      = (state == ARMED) & iValid;
    assign cnt_inc     = cnt + 1'b1;
    assign last        = accept & (cnt_inc == LAST);

    // State register.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start edge arms the block from IDLE or DONE, and
    // the accept that reaches RESULT_COUNT ends the run. A start edge while
    // armed is ignored, so there is no restart mid-run.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_pulse) state_next = ARMED;
            ARMED:   if (last)        state_next = DONE;
            DONE:    if (start_pulse) state_next = ARMED;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs. The write strobe is registered, so it
    // appears one cycle after the sample that completes a word. oBUSY is
    // dropped one cycle after entering DONE so that it still covers the
    // final strobe cycle.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            start_d    <= 1'b0;
            cnt        <= '0;
            ptr        <= '0;
            half       <= 1'b0;
            lo         <= '0;
            oBLK_ADDR  <= '0;
            oBLK_WDATA <= '0;
            oBLK_EN    <= 1'b0;
            oBLK_WE    <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            oDROP      <= 1'b0;
        end else begin
            start_d <= iSTART;
            oBLK_EN <= 1'b0;
            oBLK_WE <= '0;

            if ((state != ARMED) && start_pulse) begin
                cnt   <= '0;
                ptr   <= '0;
                half  <= 1'b0;
                oBUSY <= 1'b1;
                oDONE <= 1'b0;
                oDROP <= 1'b0;
            end else begin
                if ((state == DONE) && oBUSY) begin
                    oBUSY <= 1'b0;
                    oDONE <= 1'b1;
                end
                if ((state != ARMED) && iValid) begin
                    oDROP <= 1'b1;
                end
            end

            if (accept) begin
                cnt <= cnt_inc;
                if (half) begin
                    oBLK_EN    <= 1'b1;
                    oBLK_WE    <= '1;
                    oBLK_WDATA <= DATA_WIDTH'({iY, lo});
                    oBLK_ADDR  <= BASE + ptr;
                    ptr        <= ptr + 1'b1;
                    half       <= 1'b0;
                end else if (last) begin
                    // Odd result count: the lone final sample goes out as a half word.
                    oBLK_EN    <= 1'b1;
                    oBLK_WE    <= WEA_WIDTH'(4'b0011);
                    oBLK_WDATA <= DATA_WIDTH'({16'h0000, iY});
                    oBLK_ADDR  <= BASE + ptr;
                end else begin
                    lo   <= iY;
                    half <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_result_writer.sv
// tb_conv_result_writer
//
// Drives five instances of conv_result_writer (different result counts and
// base addresses) from one shared stimulus stream and compares every output
// of every instance, every cycle, against a sample-history model. Directed
// sequences add hand-computed literal expectations.

module tb_conv_result_writer;

    localparam int N = 5;
    localparam int CNTS  [N] = '{4, 3, 2, 4, 576};
    localparam int BASES [N] = '{'h200, 'h200, 'h200, 'h3FF, 'h200};

    logic        iCLK   = 1'b0;
    logic        iRSTn  = 1'b0;
    logic        iSTART = 1'b0;
    logic        iValid = 1'b0;
    logic [15:0] iY     = 16'h0;

    logic [N-1:0][9:0]  addr_o;
    logic [N-1:0][31:0] wdata_o;
    logic [N-1:0][3:0]  we_o;
    logic [N-1:0]       en_o;
    logic [N-1:0]       busy_o;
    logic [N-1:0]       done_o;
    logic [N-1:0]       drop_o;

    int checks = 0;
    int passes = 0;
    logic cmp_en = 1'b0;

    always #5 iCLK = ~iCLK;

    for (genvar g = 0; g < N; g++) begin : g_dut
        conv_result_writer #(
            .ADDR_WIDTH      (12),
            .DATA_WIDTH      (32),
            .WEA_WIDTH       (4),
            .RESULT_BASE_WORD(BASES[g]),
            .RESULT_COUNT    (CNTS[g]),
            .CNT_WIDTH       (10)
        ) u_dut (
            .iCLK      (iCLK),
            .iRSTn     (iRSTn),
            .iSTART    (iSTART),
            .iY        (iY),
            .iValid    (iValid),
            .oBLK_ADDR (addr_o[g]),
            .oBLK_WDATA(wdata_o[g]),
            .oBLK_EN   (en_o[g]),
            .oBLK_WE   (we_o[g]),
            .oBUSY     (busy_o[g]),
            .oDONE     (done_o[g]),
            .oDROP     (drop_o[g])
        );
    end

    // Behavioural model: keeps the list of samples accepted in the current
    // run; word k of the run is {sample[2k+1], sample[2k]} at base + k.
    logic [N-1:0][9:0]  e_addr;
    logic [N-1:0][31:0] e_data;
    logic [N-1:0][3:0]  e_we;
    logic [N-1:0]       e_en;
    logic [N-1:0]       e_busy;
    logic [N-1:0]       e_done;
    logic [N-1:0]       e_drop;
    logic [N-1:0]       running;
    logic [N-1:0]       pend;
    int                 n_m [N];
    logic [15:0]        smp [N][600];
    logic               start_prev;

    always @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            start_prev = 1'b0;
            e_addr = '0; e_data = '0; e_we = '0; e_en = '0;
            e_busy = '0; e_done = '0; e_drop = '0; running = '0; pend = '0;
            for (int i = 0; i < N; i++) n_m[i] = 0;
        end else begin
            automatic logic sp = iSTART & ~start_prev;
            start_prev = iSTART;
            for (int i = 0; i < N; i++) begin
                automatic logic was_run = running[i];
                automatic int   k;
                e_en[i] = 1'b0;
                e_we[i] = 4'h0;
                if (pend[i]) begin
                    e_busy[i] = 1'b0;
                    e_done[i] = 1'b1;
                    pend[i]   = 1'b0;
                end
                if (was_run && iValid) begin
                    smp[i][n_m[i]] = iY;
                    n_m[i]++;
                    k = n_m[i];
                    if (k % 2 == 0) begin
                        e_en[i]   = 1'b1;
                        e_we[i]   = 4'hF;
                        e_addr[i] = 10'(BASES[i] + k / 2 - 1);
                        e_data[i] = {smp[i][k-1], smp[i][k-2]};
                    end else if (k == CNTS[i]) begin
                        e_en[i]   = 1'b1;
                        e_we[i]   = 4'h3;
                        e_addr[i] = 10'(BASES[i] + k / 2);
                        e_data[i] = {16'h0000, smp[i][k-1]};
                    end
                    if (k == CNTS[i]) begin
                        running[i] = 1'b0;
                        pend[i]    = 1'b1;
                    end
                end else if (!was_run && iValid) begin
                    e_drop[i] = 1'b1;
                end
                if (sp && !was_run) begin
                    running[i] = 1'b1;
                    n_m[i]     = 0;
                    e_busy[i]  = 1'b1;
                    e_done[i]  = 1'b0;
                    e_drop[i]  = 1'b0;
                    pend[i]    = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s[%0d] actual=%0h required=%0h at %0t",
                     name, inst, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all instances against the model.
    always @(negedge iCLK) begin
        if (cmp_en) begin
            for (int i = 0; i < N; i++) begin
                checkOutput("en",    i, 32'(en_o[i]),    32'(e_en[i]));
                checkOutput("we",    i, 32'(we_o[i]),    32'(e_we[i]));
                checkOutput("addr",  i, 32'(addr_o[i]),  32'(e_addr[i]));
                checkOutput("wdata", i, wdata_o[i],      e_data[i]);
                checkOutput("busy",  i, 32'(busy_o[i]),  32'(e_busy[i]));
                checkOutput("done",  i, 32'(done_o[i]),  32'(e_done[i]));
                checkOutput("drop",  i, 32'(drop_o[i]),  32'(e_drop[i]));
            end
        end
    end

    // Inputs change on the falling edge and are consumed by the next rising edge.
    task automatic applyStimulus(input logic s, input logic v, input logic [15:0] y);
        @(negedge iCLK);
        iSTART = s;
        iValid = v;
        iY     = y;
    endtask

    task automatic doReset();
        @(posedge iCLK);
        #2;
        iRSTn  = 1'b0;
        iSTART = 1'b0;
        iValid = 1'b0;
        repeat (2) @(negedge iCLK);
        iRSTn = 1'b1;
    endtask

    initial begin
        // Reset with random inputs: everything must read 0.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'($urandom), 1'($urandom), 16'($urandom));
            checkOutput("rst_en",    0, 32'(en_o[0]),   32'h0);
            checkOutput("rst_busy",  1, 32'(busy_o[1]), 32'h0);
            checkOutput("rst_wdata", 3, wdata_o[3],     32'h0);
            checkOutput("rst_drop",  4, 32'(drop_o[4]), 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0);
        iRSTn  = 1'b1;
        cmp_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b0, 16'($urandom));
            checkOutput("idle_en", 0, 32'(en_o[0]), 32'h0);
        end

        // Four back-to-back samples.
        $display("[TB] back-to-back run");
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 16'h0001);
        checkOutput("t2_busy", 0, 32'(busy_o[0]), 32'h1);
        applyStimulus(1'b1, 1'b1, 16'h0002);
        applyStimulus(1'b1, 1'b1, 16'hFFFF);
        checkOutput("t2_en1",    0, 32'(en_o[0]),   32'h1);
        checkOutput("t2_addr1",  0, 32'(addr_o[0]), 32'h200);
        checkOutput("t2_data1",  0, wdata_o[0],     32'h00020001);
        checkOutput("t2_we1",    0, 32'(we_o[0]),   32'hF);
        checkOutput("t2_wraddr1", 3, 32'(addr_o[3]), 32'h3FF);
        checkOutput("t2_model_addr1", 0, 32'(e_addr[0]), 32'h200);
        applyStimulus(1'b1, 1'b1, 16'h8000);
        checkOutput("t2_en_gap", 0, 32'(en_o[0]), 32'h0);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t2_en2",    0, 32'(en_o[0]),   32'h1);
        checkOutput("t2_addr2",  0, 32'(addr_o[0]), 32'h201);
        checkOutput("t2_data2",  0, wdata_o[0],     32'h8000FFFF);
        checkOutput("t2_busy2",  0, 32'(busy_o[0]), 32'h1);
        checkOutput("t2_wraddr2", 3, 32'(addr_o[3]), 32'h000);
        checkOutput("t2_model_data2", 0, e_data[0], 32'h8000FFFF);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t2_done", 0, 32'(done_o[0]), 32'h1);
        checkOutput("t2_busy3", 0, 32'(busy_o[0]), 32'h0);
        checkOutput("t2_en3",  0, 32'(en_o[0]),   32'h0);

        // Odd count: final half-word write.
        $display("[TB] odd count run");
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 16'h0001);
        applyStimulus(1'b1, 1'b1, 16'h0002);
        applyStimulus(1'b1, 1'b1, 16'h1234);
        checkOutput("t3_addr1", 1, 32'(addr_o[1]), 32'h200);
        checkOutput("t3_data1", 1, wdata_o[1],     32'h00020001);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t3_en2",   1, 32'(en_o[1]),   32'h1);
        checkOutput("t3_we2",   1, 32'(we_o[1]),   32'h3);
        checkOutput("t3_addr2", 1, 32'(addr_o[1]), 32'h201);
        checkOutput("t3_data2", 1, wdata_o[1],     32'h00001234);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t3_done", 1, 32'(done_o[1]), 32'h1);

        // Gapped valids: every third cycle.
        $display("[TB] gapped run");
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 4; k++) begin
            automatic logic [15:0] vals [4] = '{16'h0001, 16'h0002, 16'hFFFF, 16'h8000};
            applyStimulus(1'b1, 1'b0, 16'h0);
            if (k == 2) begin
                checkOutput("t4_en1",   0, 32'(en_o[0]),   32'h1);
                checkOutput("t4_data1", 0, wdata_o[0],     32'h00020001);
            end
            applyStimulus(1'b1, 1'b0, 16'h0);
            if (k == 2) checkOutput("t4_en_off", 0, 32'(en_o[0]), 32'h0);
            applyStimulus(1'b1, 1'b1, vals[k]);
        end
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t4_en2",   0, 32'(en_o[0]),   32'h1);
        checkOutput("t4_addr2", 0, 32'(addr_o[0]), 32'h201);
        checkOutput("t4_data2", 0, wdata_o[0],     32'h8000FFFF);

        // Valid while idle, sticky flags, held start.
        $display("[TB] drop and restart");
        doReset();
        applyStimulus(1'b0, 1'b1, 16'h7FFF);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t5_drop", 0, 32'(drop_o[0]), 32'h1);
        checkOutput("t5_en",   0, 32'(en_o[0]),   32'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("t5_drop_clr", 0, 32'(drop_o[0]), 32'h0);
        for (int k = 0; k < 12; k++) applyStimulus(1'b1, 1'b1, 16'($urandom));
        checkOutput("t5_done_held", 0, 32'(done_o[0]), 32'h1);
        checkOutput("t5_drop_held", 0, 32'(drop_o[0]), 32'h1);
        applyStimulus(1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("t5_done_clr", 0, 32'(done_o[0]), 32'h0);
        checkOutput("t5_busy",     0, 32'(busy_o[0]), 32'h1);

        // Reset mid-run drops the latched half.
        $display("[TB] reset mid-run");
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 16'hAAAA);
        doReset();
        applyStimulus(1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b1, 16'h1111);
        applyStimulus(1'b1, 1'b1, 16'h2222);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t6_en",   2, 32'(en_o[2]),   32'h1);
        checkOutput("t6_addr", 2, 32'(addr_o[2]), 32'h200);
        checkOutput("t6_data", 2, wdata_o[2],     32'h22221111);

        // Full-size run for the 576-result instance.
        $display("[TB] full 576 run");
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 576; k++) applyStimulus(1'b1, 1'b1, 16'($urandom));
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t7_en",   4, 32'(en_o[4]),   32'h1);
        checkOutput("t7_addr", 4, 32'(addr_o[4]), 32'h31F);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("t7_done", 4, 32'(done_o[4]), 32'h1);

        // Randomized traffic with occasional start edges and resets.
        $display("[TB] random traffic");
        doReset();
        for (int c = 0; c < 5000; c++) begin
            automatic logic s = iSTART;
            if ($urandom_range(0, 39) == 0) s = ~s;
            if ($urandom_range(0, 1999) == 0) doReset();
            applyStimulus(s, ($urandom_range(0, 99) < 70), 16'($urandom));
        end

        applyStimulus(1'b0, 1'b0, 16'h0);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
